// File: rtl/ps_to_al_buffer_axi_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the PS-to-AL buffer.
package ps_to_al_buffer_axi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 8;

    localparam logic [IDX_W-1:0] REG_CTRL  = 8'h00;
    localparam logic [IDX_W-1:0] REG_STAT  = 8'h01;
    localparam logic [IDX_W-1:0] REG_COUNT = 8'h02;
    localparam logic [IDX_W-1:0] REG_SENT  = 8'h03;
    localparam logic [IDX_W-1:0] REG_DATA0 = 8'h04;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_CLEAR   = 1;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_BLOCKED = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/axil_slave_regif.sv
// AXI4-Lite slave handshake engine: turns AW/W/B and AR/R traffic into simple word-index accesses.
module axil_slave_regif
    import ps_to_al_buffer_axi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data
);

    logic              awready_q, awready_d;
    logic              bvalid_q,  bvalid_d;
    logic              wr_en_q,   wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              aw_fire, ar_fire;
    logic              unused_addr_lsb;

    // Handshake next-state: single-cycle ready pulses, responses held until accepted.
    always_comb begin
        aw_fire   = awready_q & awvalid & wvalid;
        ar_fire   = arready_q & arvalid;
        awready_d = awvalid & wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = aw_fire | (bvalid_q & ~bready);
        wr_en_d   = aw_fire;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (aw_fire) begin
            wr_idx_d  = awaddr[ADDR_W-1:2];
            wr_data_d = wdata;
        end
        arready_d = arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = ar_fire | (rvalid_q & ~rready);
        rdata_d   = ar_fire ? rd_data : rdata_q;
    end

    // Handshake state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awready = awready_q;
    assign wready  = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = 2'b00;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = 2'b00;
    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;
    // Read index is sampled on the AR acceptance cycle so rdata is captured from it.
    assign rd_en   = ar_fire;
    assign rd_idx  = araddr[ADDR_W-1:2];

    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

endmodule

// File: rtl/ps_to_al_buffer_axi.sv
// PS-to-accelerator staging buffer: word store filled over AXI-Lite, streamed out on START.
module ps_to_al_buffer_axi
    import ps_to_al_buffer_axi_pkg::*;
#(
    parameter int unsigned DEPTH = 248
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_areset,
    input  logic [ADDR_W-1:0]   s00_axi_awaddr,
    input  logic [2:0]          s00_axi_awprot,
    input  logic                s00_axi_awvalid,
    output logic                s00_axi_awready,
    input  logic [DATA_W-1:0]   s00_axi_wdata,
    input  logic [3:0]          s00_axi_wstrb,
    input  logic                s00_axi_wvalid,
    output logic                s00_axi_wready,
    output logic [1:0]          s00_axi_bresp,
    output logic                s00_axi_bvalid,
    input  logic                s00_axi_bready,
    input  logic [ADDR_W-1:0]   s00_axi_araddr,
    input  logic [2:0]          s00_axi_arprot,
    input  logic                s00_axi_arvalid,
    output logic                s00_axi_arready,
    output logic [DATA_W-1:0]   s00_axi_rdata,
    output logic [1:0]          s00_axi_rresp,
    output logic                s00_axi_rvalid,
    input  logic                s00_axi_rready,
    output logic [DATA_W-1:0]   al_data,
    output logic                al_valid,
    input  logic                al_ready,
    output logic                al_last,
    output logic                buffer_write_fin
);

    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned DATA_END = 4 + DEPTH;

    logic              wr_en, rd_en;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] wr_data, rd_data_c;
    logic              unused_inputs;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     sent_q, sent_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] al_data_q, al_data_d;
    logic              al_valid_q, al_valid_d;
    logic              al_last_q, al_last_d;
    logic              fin_q, fin_d;
    logic              done_q, done_d;
    logic              blocked_q, blocked_d;

    logic              busy_c, ctrl_wr_c, start_c, clear_c, data_wr_c;

    axil_slave_regif u_regif (
        .clk     (s00_axi_aclk),
        .rst     (s00_axi_areset),
        .awaddr  (s00_axi_awaddr),
        .awvalid (s00_axi_awvalid),
        .awready (s00_axi_awready),
        .wdata   (s00_axi_wdata),
        .wvalid  (s00_axi_wvalid),
        .wready  (s00_axi_wready),
        .bresp   (s00_axi_bresp),
        .bvalid  (s00_axi_bvalid),
        .bready  (s00_axi_bready),
        .araddr  (s00_axi_araddr),
        .arvalid (s00_axi_arvalid),
        .arready (s00_axi_arready),
        .rdata   (s00_axi_rdata),
        .rresp   (s00_axi_rresp),
        .rvalid  (s00_axi_rvalid),
        .rready  (s00_axi_rready),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data_c)
    );

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb, rd_en};

    // Register-read mux; storage reads see the value before any same-cycle write.
    always_comb begin
        rd_data_c = '0;
        if (rd_idx == REG_STAT) begin
            rd_data_c[STAT_BUSY]    = (state_q != ST_IDLE);
            rd_data_c[STAT_DONE]    = done_q;
            rd_data_c[STAT_BLOCKED] = blocked_q;
        end else if (rd_idx == REG_COUNT) begin
            rd_data_c = DATA_W'(count_q);
        end else if (rd_idx == REG_SENT) begin
            rd_data_c = DATA_W'(sent_q);
        end else if (rd_idx >= REG_DATA0 && 32'(rd_idx) < DATA_END) begin
            rd_data_c = mem_q[AW'(rd_idx - REG_DATA0)];
        end
    end

    // Control decode, register updates and stream FSM next-state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sent_d      = sent_q;
        idx_d       = idx_q;
        al_data_d   = al_data_q;
        al_valid_d  = al_valid_q;
        al_last_d   = al_last_q;
        fin_d       = 1'b0;
        done_d      = done_q;
        blocked_d   = blocked_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = AW'(wr_idx - REG_DATA0);

        busy_c    = (state_q != ST_IDLE);
        ctrl_wr_c = wr_en && (wr_idx == REG_CTRL);
        start_c   = ctrl_wr_c && wr_data[CTRL_START];
        clear_c   = ctrl_wr_c && wr_data[CTRL_CLEAR];
        data_wr_c = wr_en && (wr_idx >= REG_DATA0) && (32'(wr_idx) < DATA_END);

        if (data_wr_c) begin
            if (busy_c) begin
                blocked_d = 1'b1;
            end else begin
                mem_we_c = 1'b1;
            end
        end

        if (wr_en && (wr_idx == REG_COUNT) && !busy_c) begin
            count_d = (wr_data > DATA_W'(DEPTH)) ? CW'(DEPTH) : CW'(wr_data);
        end

        if (clear_c) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            sent_d     = '0;
            done_d     = 1'b0;
            blocked_d  = 1'b0;
            al_valid_d = 1'b0;
            al_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        sent_d = '0;
                        done_d = 1'b0;
                        if (count_q == '0) begin
                            state_d = ST_DONE;
                            fin_d   = 1'b1;
                        end else begin
                            state_d    = ST_SEND;
                            idx_d      = '0;
                            al_data_d  = mem_q[0];
                            al_valid_d = 1'b1;
                            al_last_d  = (count_q == CW'(1));
                        end
                    end
                end
                ST_SEND: begin
                    if (al_valid_q && al_ready) begin
                        sent_d = sent_q + CW'(1);
                        if (al_last_q) begin
                            al_valid_d = 1'b0;
                            al_last_d  = 1'b0;
                            state_d    = ST_DONE;
                            fin_d      = 1'b1;
                        end else begin
                            idx_d     = idx_q + CW'(1);
                            al_data_d = mem_q[AW'(idx_q + CW'(1))];
                            al_last_d = ((idx_q + CW'(2)) == count_q);
                        end
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Word storage; intentionally not cleared by reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= wr_data;
        end
    end

    // State and register flops.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sent_q     <= '0;
            idx_q      <= '0;
            al_data_q  <= '0;
            al_valid_q <= 1'b0;
            al_last_q  <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            idx_q      <= idx_d;
            al_data_q  <= al_data_d;
            al_valid_q <= al_valid_d;
            al_last_q  <= al_last_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            blocked_q  <= blocked_d;
        end
    end

    assign al_data          = al_data_q;
    assign al_valid         = al_valid_q;
    assign al_last          = al_last_q;
    assign buffer_write_fin = fin_q;

endmodule

// File: tb/tb_ps_to_al_buffer_axi.sv
// Self-checking bench for ps_to_al_buffer_axi: AXI-Lite register access and stream scoreboard.
module tb_ps_to_al_buffer_axi;

    logic        clk = 1'b0;
    logic        areset;
    logic [9:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] al_data;
    logic        al_valid, al_ready, al_last, fin;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int valid_cycles = 0;
    int fin_cnt = 0;
    bit stall_chk_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    ps_to_al_buffer_axi dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .al_data(al_data), .al_valid(al_valid),
        .al_ready(al_ready), .al_last(al_last), .buffer_write_fin(fin)
    );

    // Stream monitor: scoreboard pop on each handshake, stability check while stalled.
    always @(negedge clk) begin
        if (!areset) begin
            if (fin) fin_cnt++;
            if (al_valid) valid_cycles++;
            if (al_valid && al_ready) begin
                logic [32:0] e;
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got last=%0b data=%h", al_last, al_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({al_last, al_data} !== e) begin
                        errors++;
                        $display("FAIL beat got last=%0b data=%h want last=%0b data=%h",
                                 al_last, al_data, e[32], e[31:0]);
                    end
                end
            end
            if (stall_chk_en && prev_stall) begin
                checks++;
                if (!al_valid || al_data !== prev_data || al_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                             al_valid, al_data, al_last, prev_data, prev_last);
                end
            end
            prev_stall = al_valid && !al_ready;
            prev_data  = al_data;
            prev_last  = al_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic axi_write(input logic [7:0] idx, input logic [31:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        awaddr = {idx, 2'b00}; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready && wready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL aw_timeout idx=%h got awready=0 want 1", idx); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bvalid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got || bresp !== 2'b00) begin
            errors++;
            $display("FAIL b_resp idx=%h got bvalid=%0b bresp=%0d want 1/0", idx, bvalid, bresp);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [7:0] idx, output logic [31:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        araddr = {idx, 2'b00}; arvalid = 1'b1; rready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL ar_timeout idx=%h got arready=0 want 1", idx); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rvalid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        d = rdata;
        if (!got) begin
            errors++;
            $display("FAIL r_timeout idx=%h got rvalid=0 want 1", idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_fin(input int f0, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (fin_cnt > f0) break;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, al_valid, al_last, fin} !== 8'h00
            || al_data !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b al_data=%h rdata=%h want 0",
                     {awready, wready, bvalid, arready, rvalid, al_valid, al_last, fin}, al_data, rdata);
        end
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    task automatic test_stream_basic();
        logic [31:0] r;
        int f0, b0;
        for (int i = 0; i < 4; i++) axi_write(8'(4 + i), 32'hA0 + 32'(i));
        axi_write(8'h02, 32'd4);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'hA0 + 32'(i)});
        f0 = fin_cnt; b0 = beats;
        al_ready = 1'b1;
        axi_write(8'h00, 32'h1);
        wait_fin(f0, 100);
        repeat (3) @(negedge clk);
        checks++;
        if (beats - b0 != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_beats got %0d left=%0d want 4 left=0", beats - b0, exp_q.size());
        end
        checks++;
        if (fin_cnt - f0 != 1) begin errors++; $display("FAIL basic_fin got %0d want 1", fin_cnt - f0); end
        axi_read(8'h01, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL basic_stat got %h want 2", r); end
        axi_read(8'h03, r);
        checks++;
        if (r !== 32'd4) begin errors++; $display("FAIL basic_sent got %0d want 4", r); end
        al_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] r;
        int f0, b0;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'hA0 + 32'(i)});
        f0 = fin_cnt; b0 = beats;
        al_ready = 1'b0;
        stall_chk_en = 1'b1;
        axi_write(8'h00, 32'h1);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            al_ready = ~al_ready;
            if (fin_cnt > f0) break;
        end
        al_ready = 1'b0;
        repeat (2) @(negedge clk);
        stall_chk_en = 1'b0;
        checks++;
        if (beats - b0 != 4 || exp_q.size() != 0 || fin_cnt - f0 != 1) begin
            errors++;
            $display("FAIL stall_stream got beats=%0d left=%0d fin=%0d want 4/0/1",
                     beats - b0, exp_q.size(), fin_cnt - f0);
        end
        axi_read(8'h03, r);
        checks++;
        if (r !== 32'd4) begin errors++; $display("FAIL stall_sent got %0d want 4", r); end
    endtask

    task automatic test_count_zero();
        logic [31:0] r;
        int f0, v0;
        axi_write(8'h02, 32'd0);
        f0 = fin_cnt; v0 = valid_cycles;
        al_ready = 1'b1;
        axi_write(8'h00, 32'h1);
        repeat (10) @(negedge clk);
        al_ready = 1'b0;
        checks++;
        if (valid_cycles != v0 || fin_cnt - f0 != 1) begin
            errors++;
            $display("FAIL zero_count got valid=%0d fin=%0d want 0/1", valid_cycles - v0, fin_cnt - f0);
        end
        axi_read(8'h01, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL zero_stat got %h want 2", r); end
        axi_write(8'h02, 32'd300);
        axi_read(8'h02, r);
        checks++;
        if (r !== 32'd248) begin errors++; $display("FAIL count_clamp got %0d want 248", r); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        int f0;
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) axi_write(8'(4 + i), 32'hB0 + 32'(i));
        axi_write(8'h02, 32'd8);
        exp_q.push_back({1'b0, 32'hB0});
        exp_q.push_back({1'b0, 32'hB1});
        al_ready = 1'b0;
        f0 = fin_cnt;
        axi_write(8'h00, 32'h1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (al_valid) begin got = 1'b1; break; end
        end
        al_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        al_ready = 1'b0;
        checks++;
        if (!got || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_two_beats got valid_seen=%0b left=%0d want 1/0", got, exp_q.size());
        end
        axi_read(8'h03, r);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL abort_sent got %0d want 2", r); end
        axi_write(8'h04, 32'hDEAD);
        axi_read(8'h01, r);
        checks++;
        if (r !== 32'h5) begin errors++; $display("FAIL abort_blocked_stat got %h want 5", r); end
        axi_read(8'h04, r);
        checks++;
        if (r !== 32'hB0) begin errors++; $display("FAIL abort_storage got %h want b0", r); end
        axi_write(8'h00, 32'h1);
        axi_read(8'h03, r);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL start_while_busy got sent=%0d want 2", r); end
        axi_write(8'h00, 32'h3);
        checks++;
        if (al_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %0b want 0", al_valid); end
        repeat (5) @(negedge clk);
        checks++;
        if (fin_cnt != f0) begin errors++; $display("FAIL clear_fin got %0d want 0", fin_cnt - f0); end
        axi_read(8'h02, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL clear_count got %0d want 0", r); end
        axi_read(8'h01, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL clear_stat got %h want 0", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int f0, b0;
        bit got = 1'b0;
        axi_write(8'h02, 32'd8);
        al_ready = 1'b0;
        axi_write(8'h00, 32'h1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (al_valid) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rst_mid_start got valid=0 want 1"); end
        f0 = fin_cnt;
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (al_valid !== 1'b0 || al_last !== 1'b0 || al_data !== 32'h0 || fin !== 1'b0
            || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%0b l=%0b d=%h fin=%0b want 0", al_valid, al_last, al_data, fin);
        end
        areset = 1'b0;
        axi_read(8'h02, r);
        checks++;
        if (r !== 32'd0 || fin_cnt != f0) begin
            errors++;
            $display("FAIL rst_mid_count got count=%0d fin=%0d want 0/0", r, fin_cnt - f0);
        end
        b0 = beats;
        al_ready = 1'b1;
        axi_write(8'h00, 32'h1);
        repeat (10) @(negedge clk);
        al_ready = 1'b0;
        checks++;
        if (beats != b0 || fin_cnt - f0 != 1) begin
            errors++;
            $display("FAIL rst_then_start got beats=%0d fin=%0d want 0/1", beats - b0, fin_cnt - f0);
        end
    endtask

    task automatic test_axi_hold();
        logic [31:0] r;
        int pulses = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        bready = 1'b0;
        awaddr = {8'h02, 2'b00}; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (awready) pulses++;
        end
        checks++;
        if (pulses != 1 || bvalid !== 1'b1) begin
            errors++;
            $display("FAIL bhold got awready_pulses=%0d bvalid=%0b want 1/1", pulses, bvalid);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (awready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL bhold_release got awready=0 want 1"); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(posedge clk); #1;
        pulses = 0;
        rready = 1'b0;
        araddr = {8'hFF, 2'b00}; arvalid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (arready) pulses++;
        end
        checks++;
        if (pulses != 1 || rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rhold got arready_pulses=%0d rvalid=%0b rdata=%h want 1/1/0", pulses, rvalid, rdata);
        end
        @(posedge clk); #1;
        rready = 1'b1; arvalid = 1'b0;
        axi_read(8'h02, r);
        checks++;
        if (r !== 32'd5) begin errors++; $display("FAIL hold_count got %0d want 5", r); end
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1; al_ready = 1'b0;
        test_reset();
        test_stream_basic();
        test_stall();
        test_count_zero();
        test_abort();
        test_reset_mid();
        test_axi_hold();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
